// File: rtl/fetch_pc_predict.sv
// Fetch-stage PC register with a direct-mapped BTB and 2-bit saturating counters.
// Lookup is combinational on PCF; training and redirects come from execute.
module fetch_pc_predict #(
    parameter int          BTB_ENTRIES = 16,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [31:0] PCF,
    output logic [31:0] PCPlus4F,
    output logic        predict_taken_F,
    input  logic        branch_valid_E,
    input  logic        branch_taken_E,
    input  logic [31:0] branch_pc_E,
    input  logic [31:0] branch_target_E,
    input  logic        mispredict_E,
    input  logic [31:0] redirect_pc_E
);
    localparam int IDX   = $clog2(BTB_ENTRIES);
    localparam int TAG_W = 30 - IDX;

    typedef enum logic [1:0] {
        STRONG_NT = 2'b00,
        WEAK_NT   = 2'b01,
        WEAK_T    = 2'b10,
        STRONG_T  = 2'b11
    } ctr_t;

    logic [BTB_ENTRIES-1:0] valid_q;
    ctr_t                   ctr_q    [BTB_ENTRIES];
    logic [TAG_W-1:0]       tag_q    [BTB_ENTRIES];
    logic [31:0]            target_q [BTB_ENTRIES];

    // Fetch-side lookup
    logic [IDX-1:0]   f_idx;
    logic [TAG_W-1:0] f_tag;
    logic             f_hit;
    logic [31:0]      pred_target;
    logic [31:0]      next_pc;

    assign f_idx           = PCF[IDX+1:2];
    assign f_tag           = PCF[31:IDX+2];
    assign f_hit           = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    assign predict_taken_F = f_hit && ctr_q[f_idx][1];
    assign pred_target     = target_q[f_idx];
    assign PCPlus4F        = PCF + 32'd4;

    // Execute-side training
    logic [IDX-1:0]   u_idx;
    logic [TAG_W-1:0] u_tag;
    logic             u_hit;
    logic             ctr_wr;
    logic             tgt_wr;
    logic             alloc;
    ctr_t             ctr_next;

    assign u_idx = branch_pc_E[IDX+1:2];
    assign u_tag = branch_pc_E[31:IDX+2];
    assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        ctr_next = ctr_q[u_idx];
        ctr_wr   = 1'b0;
        tgt_wr   = 1'b0;
        alloc    = 1'b0;
        if (branch_valid_E) begin
            if (u_hit) begin
                ctr_wr = 1'b1;
                tgt_wr = branch_taken_E;
                if (branch_taken_E) begin
                    if (ctr_q[u_idx] != STRONG_T)
                        ctr_next = ctr_t'(ctr_q[u_idx] + 2'd1);
                end else begin
                    if (ctr_q[u_idx] != STRONG_NT)
                        ctr_next = ctr_t'(ctr_q[u_idx] - 2'd1);
                end
            end else if (branch_taken_E) begin
                ctr_wr   = 1'b1;
                tgt_wr   = 1'b1;
                alloc    = 1'b1;
                ctr_next = WEAK_T;
            end
        end
    end

    // A redirect wins over a stall so it is never lost.
    always_comb begin
        next_pc = PCF;
        if (mispredict_E)
            next_pc = redirect_pc_E;
        else if (en && predict_taken_F)
            next_pc = pred_target;
        else if (en)
            next_pc = PCPlus4F;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            PCF <= RESET_PC;
        else
            PCF <= next_pc;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            for (int i = 0; i < BTB_ENTRIES; i++)
                ctr_q[i] <= WEAK_NT;
        end else begin
            if (ctr_wr)
                ctr_q[u_idx] <= ctr_next;
            if (alloc)
                valid_q[u_idx] <= 1'b1;
        end
    end

    // NOTE: tags and targets are qualified by valid_q, so this storage is left without reset.
    always_ff @(posedge clk) begin
        if (rst && tgt_wr)
            target_q[u_idx] <= branch_target_E;
        if (rst && alloc)
            tag_q[u_idx] <= u_tag;
    end

endmodule

// File: doc/fetch_pc_predict.md
Name: fetch_pc_predict

Overview:
Fetch-stage front end. Holds the program counter and produces PCF, PCPlus4F and predict_taken_F for the fetch-to-decode pipeline register. A direct-mapped branch target buffer (BTB) with 2-bit saturating counters supplies next-PC prediction. The BTB is trained by resolved branches from the execute stage, and the PC is redirected on a mispredict.

Parameters:
BTB_ENTRIES, 16, number of BTB entries; power of two, 2..256.
RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  asynchronous, active-low reset.
en  input  1  fetch enable; 0 = stall, PC holds.
PCF  output  32  current fetch PC; drives instruction memory address.
PCPlus4F  output  32  PCF + 4.
predict_taken_F  output  1  BTB predicts current PCF is a taken branch.
branch_valid_E  input  1  execute stage has a resolved control-flow instruction this cycle.
branch_taken_E  input  1  resolved direction.
branch_pc_E  input  32  PC of the resolved instruction.
branch_target_E  input  32  resolved taken target.
mispredict_E  input  1  execute detected a wrong prediction; redirect fetch.
redirect_pc_E  input  32  correct next PC on mispredict.

Behaviour:
- Reset (rst=0, async):
  - PCF = RESET_PC.
  - All BTB valid bits = 0.
  - All counters = 2'b01 (weakly not-taken).
  - Targets and tags are don't-care.
  - Outputs are valid immediately after reset: PCPlus4F = RESET_PC+4, predict_taken_F = 0.
- Address fields: IDX = log2(BTB_ENTRIES). index = PC[IDX+1:2]; tag = PC[31:IDX+2].
- Lookup (combinational on PCF):
  - hit = valid[index] & (tag[index] == PCF tag).
  - predict_taken_F = hit & counter[index][1].
  - pred_target = target[index].
- PCPlus4F = PCF + 4, modulo 2^32 (wraps from 32'hFFFF_FFFC to 0).
- Next-PC priority, applied at the clock edge:
  1. mispredict_E = 1 → PCF <= redirect_pc_E. Overrides en=0; a redirect is never lost to a stall.
  2. else en = 1 and predict_taken_F → PCF <= pred_target.
  3. else en = 1 → PCF <= PCPlus4F.
  4. else hold.
- BTB update (on edge when branch_valid_E = 1; index and tag taken from branch_pc_E). The update is independent of en and mispredict_E.
  - Entry hit (valid and tag match):
    - counter saturating +1 if taken, -1 if not taken (11 stays 11, 00 stays 00).
    - If taken, target <= branch_target_E.
  - Entry miss and taken: allocate/replace the entry. valid = 1, tag written, target <= branch_target_E, counter = 2'b10 (weakly taken).
  - Entry miss and not taken: no change.
- Simultaneous lookup and update to the same index: the lookup sees the pre-update contents. The write is visible from the next cycle. There is no write-to-read bypass.
- Counter state encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Prediction uses bit [1].
- Reset asserted mid-operation clears state asynchronously. Any in-flight update that same cycle is discarded.
- Latency:
  - Prediction is zero-cycle (same cycle as PCF).
  - Training takes effect one cycle after branch_valid_E.
  - Redirect takes effect one cycle after mispredict_E.

Test Plan:
- Reset release, RESET_PC=0, en=1, no branches, 4 cycles → PCF sequence 0,4,8,12; predict_taken_F=0 throughout.
- Allocation then prediction: branch_valid_E=1, taken=1, branch_pc_E=0x40, target 0x100 for one cycle. Later fetch reaches PCF=0x40 → predict_taken_F=1 and next PCF=0x100.
- Counter saturation at PC 0x40 (allocated, counter 10):
  - 3 not-taken updates → counter 01 then 00 then stays 00. Fetch at 0x40 predicts 0 and next PC = 0x44.
  - 3 taken updates → 01, 10, 11. Predicts 1.
- Tag alias, BTB_ENTRIES=16: entry allocated for 0x40. Fetch at 0x440 (same index, different tag) → predict_taken_F=0. Not-taken update at 0x440 leaves the 0x40 entry intact. Taken update at 0x440 replaces it, and 0x40 then misses.
- Stall vs redirect: en=0 for 3 cycles → PCF holds. During the stall, mispredict_E=1 with redirect_pc_E=0x200 → PCF=0x200 next cycle despite en=0.
- Same-cycle hazard and async reset:
  - Update to the index currently being looked up → current-cycle predict_taken_F reflects old state; the following cycle reflects the new state.
  - Assert rst=0 between edges → PCF=RESET_PC immediately and all entries invalid.
